switch_tx_scheduler: RTL and testbench

Per-egress-port frame scheduler for the switch. It arbitrates round-robin between N ingress frame buffers that each hold a complete received frame. It reads the winner's bytes out at one byte per clock and drives a GMII-style transmit stream: preamble, SFD, then the payload including the FCS. It enforces the inter-frame gap and silently flushes frames whose length is illegal.

---
 rtl/eth_sw_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 90 +++++++++
 rtl/switch_tx_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_switch_tx_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_sw_pkg
//  Description : Shared constants, state encoding and helpers for the switch
//                egress transmit scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_sw_pkg;

  // GMII framing bytes
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PRE_LEN       = 8;

  // Legal Ethernet frame length window, DA through FCS
  localparam int ETH_MIN_LEN = 64;
  localparam int ETH_MAX_LEN = 1518;

  // Width of the frame length field carried by each ingress
  localparam int LEN_W = 11;

  // Scheduler states, explicitly encoded
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SEND  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_IFG   = 3'd4
  } sched_state_e;

  // Bits needed to index n items; never less than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin picker. Combinationally selects the first
//                requester at or above the priority pointer (with wrap) and
//                moves the pointer just past the winner on an advance strobe.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_clk        : clock, rising edge
//    i_rst_n      : synchronous active-low reset (pointer returns to 0)
//    i_req        : request vector
//    i_advance    : commit the current pick and rotate the pointer
//    o_grant      : one-hot pick (all zero when nothing requests)
//    o_grant_idx  : binary index of the pick
//    o_valid      : at least one requester present
// ============================================================================
module rr_arbiter
  import eth_sw_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_valid
);

  // One extra bit so ptr + offset never overflows before the wrap
  localparam int              CW     = IDX_W + 1;
  localparam logic [CW-1:0]   N_C    = CW'(N);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(N - 1);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [CW-1:0]    cand;

  // Walk offsets from highest to lowest so the smallest offset from the
  // pointer is the last (and therefore winning) assignment.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= N_C) begin
        cand = cand - N_C;
      end
      if (i_req[cand[IDX_W-1:0]]) begin
        pick_idx   = cand[IDX_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (pick_found) begin
      o_grant[pick_idx] = 1'b1;
    end
  end

  assign o_grant_idx = pick_idx;
  assign o_valid     = pick_found;

  // Pointer moves only on a committed grant, so a gated requester keeps
  // its place in the rotation.
  always_comb begin
    ptr_d = ptr_q;
    if (i_advance && pick_found) begin
      ptr_d = (pick_idx == LAST_C) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : switch_tx_scheduler
//  Description : Per-egress-port frame scheduler. Round-robin selects one of
//                N ingress frame buffers, streams preamble + SFD + frame on a
//                GMII-style byte interface, inserts the inter-frame gap and
//                silently drains frames whose length is out of range.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_clk      : clock, rising edge
//    i_rst_n    : synchronous active-low reset
//    i_tx_en    : allows a new arbitration (a running frame always completes)
//    i_req      : per-ingress "complete frame available"
//    i_len      : per-ingress frame length, 11 bits each
//    i_rd_data  : per-ingress read byte, valid one cycle after o_rd_en
//    o_grant    : one-hot current owner, zero when no owner
//    o_rd_en    : read strobe to the owner
//    o_done     : one-cycle pulse when the owner's frame is sent or flushed
//    o_drop     : one-cycle pulse alongside o_done for a flushed frame
//    o_tx_dv    : transmit data valid
//    o_tx_d     : transmit byte (zero when o_tx_dv is low)
//    o_busy     : high whenever the scheduler is not idle
// ============================================================================
module switch_tx_scheduler
  import eth_sw_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = ETH_MIN_LEN,
  parameter int MAX_LEN    = ETH_MAX_LEN
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_tx_en,
  input  logic [N_PORTS-1:0]       i_req,
  input  logic [N_PORTS*11-1:0]    i_len,
  input  logic [N_PORTS*8-1:0]     i_rd_data,
  output logic [N_PORTS-1:0]       o_grant,
  output logic [N_PORTS-1:0]       o_rd_en,
  output logic [N_PORTS-1:0]       o_done,
  output logic                     o_drop,
  output logic                     o_tx_dv,
  output logic [7:0]               o_tx_d,
  output logic                     o_busy
);

  localparam int                IDX_W    = idx_width(N_PORTS);
  localparam int                IFG_W    = idx_width(IFG_CYCLES + 1);
  localparam logic [LEN_W-1:0]  MIN_L    = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]  MAX_L    = LEN_W'(MAX_LEN);
  localparam logic [IFG_W-1:0]  IFG_LAST = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [2:0]        PRE_LAST = 3'(PRE_LEN - 1);

  // Registered state
  sched_state_e       state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   win_q,   win_d;
  logic [LEN_W-1:0]   len_q,   len_d;   // remaining bytes of the frame
  logic [2:0]         pre_q,   pre_d;   // preamble byte index
  logic [IFG_W-1:0]   ifg_q,   ifg_d;   // remaining gap cycles

  // Combinational controls
  logic [N_PORTS-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               arb_take;
  logic [LEN_W-1:0]   sel_len;
  logic               len_ok;
  logic [7:0]         rd_byte;
  logic [LEN_W-1:0]   len_dec;
  logic               tx_dv;
  logic [7:0]         tx_byte;
  logic               rd;
  logic               done;
  logic               drop;

  assign arb_take = (state_q == ST_IDLE) && i_tx_en && arb_valid;

  rr_arbiter #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_advance   (arb_take),
    .o_grant     (arb_grant),
    .o_grant_idx (arb_idx),
    .o_valid     (arb_valid)
  );

  // Length of the candidate winner, examined before the grant is latched
  always_comb begin
    sel_len = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (arb_idx == IDX_W'(p)) begin
        sel_len = i_len[p*LEN_W +: LEN_W];
      end
    end
  end

  assign len_ok = (sel_len >= MIN_L) && (sel_len <= MAX_L);

  // Read data of the latched winner
  always_comb begin
    rd_byte = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (win_q == IDX_W'(p)) begin
        rd_byte = i_rd_data[p*8 +: 8];
      end
    end
  end

  // Saturating decrement keeps the counter from wrapping if a zero length
  // ever reaches a counting state.
  assign len_dec = (len_q != '0) ? len_q - LEN_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    win_d   = win_q;
    len_d   = len_q;
    pre_d   = pre_q;
    ifg_d   = ifg_q;
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    rd      = 1'b0;
    done    = 1'b0;
    drop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_take) begin
          grant_d = arb_grant;
          win_d   = arb_idx;
          len_d   = sel_len;
          pre_d   = '0;
          state_d = len_ok ? ST_PRE : ST_FLUSH;
        end
      end

      ST_PRE: begin
        tx_dv = 1'b1;
        if (pre_q == PRE_LAST) begin
          // First read is issued under the SFD so byte 0 lands on the
          // first SEND cycle.
          tx_byte = SFD_BYTE;
          rd      = 1'b1;
          state_d = ST_SEND;
        end else begin
          tx_byte = PREAMBLE_BYTE;
          pre_d   = pre_q + 3'd1;
        end
      end

      ST_SEND: begin
        tx_dv   = 1'b1;
        tx_byte = rd_byte;
        len_d   = len_dec;
        if (len_q <= LEN_W'(1)) begin
          done    = 1'b1;
          grant_d = '0;
          ifg_d   = IFG_LAST;
          state_d = (IFG_CYCLES > 0) ? ST_IFG : ST_IDLE;
        end else begin
          // One read was already issued in PRE, so stop one byte early.
          rd = 1'b1;
        end
      end

      ST_FLUSH: begin
        rd    = (len_q != '0);
        len_d = len_dec;
        if (len_q <= LEN_W'(1)) begin
          done    = 1'b1;
          drop    = 1'b1;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end

      ST_IFG: begin
        if (ifg_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          ifg_d = ifg_q - IFG_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      win_q   <= '0;
      len_q   <= '0;
      pre_q   <= '0;
      ifg_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      len_q   <= len_d;
      pre_q   <= pre_d;
      ifg_q   <= ifg_d;
    end
  end

  // grant_q is zero outside PRE/SEND/FLUSH, so the per-port strobes are
  // automatically quiet in IDLE and IFG.
  assign o_grant = grant_q;
  assign o_rd_en = grant_q & {N_PORTS{rd}};
  assign o_done  = grant_q & {N_PORTS{done}};
  assign o_drop  = drop;
  assign o_tx_dv = tx_dv;
  assign o_tx_d  = tx_byte;
  assign o_busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_switch_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_tx_scheduler
//  Description : Directed self-checking bench for switch_tx_scheduler with
//                a simple ingress buffer responder and a stream monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_tx_scheduler;

  localparam int NP = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tx_en;
  logic [NP-1:0]     req;
  logic [NP*11-1:0]  len_v;
  logic [NP*8-1:0]   rd_data;
  logic [NP-1:0]     grant;
  logic [NP-1:0]     rd_en;
  logic [NP-1:0]     done;
  logic              drop;
  logic              tx_dv;
  logic [7:0]        tx_d;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  switch_tx_scheduler #(
    .N_PORTS    (NP),
    .IFG_CYCLES (12),
    .MIN_LEN    (64),
    .MAX_LEN    (1518)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_tx_en   (tx_en),
    .i_req     (req),
    .i_len     (len_v),
    .i_rd_data (rd_data),
    .o_grant   (grant),
    .o_rd_en   (rd_en),
    .o_done    (done),
    .o_drop    (drop),
    .o_tx_dv   (tx_dv),
    .o_tx_d    (tx_d),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  // Content of byte k in ingress p's buffer
  function automatic logic [7:0] ing_byte(input int p, input int k);
    return 8'((k + 40 * p) & 255);
  endfunction

  // Ingress buffers: each read strobe returns the next byte one cycle later
  int rd_ptr [NP];
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      for (int p = 0; p < NP; p++) rd_ptr[p] <= 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (rd_en[p]) begin
          rd_data[p*8 +: 8] <= ing_byte(p, rd_ptr[p]);
          rd_ptr[p]         <= rd_ptr[p] + 1;
        end
        if (done[p]) rd_ptr[p] <= 0;
      end
    end
  end

  // Stream monitor, cumulative counters sampled on the falling edge
  int         dv_cnt    = 0;
  int         proto_err = 0;
  int         rd_cnt   [NP] = '{default: 0};
  int         done_cnt [NP] = '{default: 0};
  logic [7:0] tx_q [$];
  int         done_log [$];
  int         run_q [$];
  int         gap_q [$];
  int         cur_run = 0;
  int         cur_gap = 0;
  bit         prev_dv = 1'b0;
  bit         seen_dv = 1'b0;

  always @(negedge clk) begin
    if (tx_dv === 1'b1) begin
      tx_q.push_back(tx_d);
      dv_cnt++;
      if (!prev_dv && seen_dv) gap_q.push_back(cur_gap);
      cur_run++;
      cur_gap = 0;
      seen_dv = 1'b1;
    end else begin
      if (prev_dv) begin
        run_q.push_back(cur_run);
        cur_run = 0;
      end
      cur_gap++;
      if (tx_d !== 8'h00) proto_err++;
    end
    prev_dv = (tx_dv === 1'b1);
    for (int p = 0; p < NP; p++) begin
      if (rd_en[p] === 1'b1) rd_cnt[p]++;
      if (done[p] === 1'b1) begin
        done_cnt[p]++;
        done_log.push_back(p);
      end
    end
    if (drop === 1'b1 && done === '0) proto_err++;
    if (!$onehot0(grant)) proto_err++;
    if (!$onehot0(done)) proto_err++;
    if ((rd_en & ~grant) !== '0) proto_err++;
  end

  // Step to just after the next falling edge: outputs are stable and the
  // monitor has already updated; inputs driven here land before the next
  // rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int p, input int v);
    len_v[p*11 +: 11] = 11'(v);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done === '0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(done !== '0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_tx, s_dv, s_rd, s_log, s_run, s_gap, s_done0, nerr;
    logic [7:0] eb;
    int exp_order [5];

    rst_n = 1'b0;
    tx_en = 1'b0;
    req   = '0;
    len_v = '0;
    repeat (3) tick();

    // ---- reset state ----
    chk("rst_grant", grant, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_dv",    tx_dv, 0);
    chk("rst_txd",   tx_d,  0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_done_drop", {drop, done}, 0);
    rst_n = 1'b1;
    tick();

    // ---- 1: single legal frame ----
    set_len(0, 64);
    s_tx  = tx_q.size();
    s_rd  = rd_cnt[0];
    s_run = run_q.size();
    tx_en = 1'b1;
    req   = 4'b0001;
    tick();
    chk("t1_first_dv",   tx_dv, 1);
    chk("t1_grant",      grant, 4'b0001);
    chk("t1_first_byte", tx_d,  8'h55);
    wait_done("t1_wait", 200);
    chk("t1_done",   done, 4'b0001);
    chk("t1_no_drop", drop, 0);
    chk("t1_dv_at_done", tx_dv, 1);
    req = '0;
    nerr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!(busy === 1'b1 && tx_dv === 1'b0 && grant === '0)) nerr++;
    end
    chk("t1_ifg", nerr, 0);
    tick();
    chk("t1_idle_after_ifg", busy, 0);
    chk("t1_rd_strobes", rd_cnt[0] - s_rd, 64);
    chk("t1_len", tx_q.size() - s_tx, 72);
    nerr = 0;
    for (int i = 0; i < 72; i++) begin
      if (i < 7)       eb = 8'h55;
      else if (i == 7) eb = 8'hD5;
      else             eb = ing_byte(0, i - 8);
      if (tx_q[s_tx + i] !== eb) nerr++;
    end
    chk("t1_bytes", nerr, 0);
    chk("t1_run", run_q[s_run], 72);

    // ---- 2: round robin, all ports continuously requesting ----
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) set_len(p, 64);
    s_log = done_log.size();
    s_gap = gap_q.size();
    s_run = run_q.size();
    req   = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_done("t2_wait", 200);
      tick();
    end
    req = '0;
    repeat (14) tick();
    exp_order = '{0, 1, 2, 3, 0};
    for (int f = 0; f < 5; f++) chk("t2_order", done_log[s_log + f], exp_order[f]);
    nerr = 0;
    for (int f = 1; f < 5; f++) if (gap_q[s_gap + f] != 13) nerr++;
    chk("t2_gaps", nerr, 0);
    nerr = 0;
    for (int f = 0; f < 5; f++) if (run_q[s_run + f] != 72) nerr++;
    chk("t2_runs", nerr, 0);

    // ---- 3a: short frame flushed ----
    set_len(2, 20);
    s_rd = rd_cnt[2];
    s_dv = dv_cnt;
    req  = 4'b0100;
    tick();
    chk("t3_grant", grant, 4'b0100);
    chk("t3_rd",    rd_en, 4'b0100);
    chk("t3_busy",  busy,  1);
    wait_done("t3_wait", 100);
    chk("t3_done", done, 4'b0100);
    chk("t3_drop", drop, 1);
    req = '0;
    tick();
    chk("t3_no_ifg", busy, 0);
    chk("t3_reads", rd_cnt[2] - s_rd, 20);
    chk("t3_no_dv", dv_cnt - s_dv, 0);

    // ---- 3b: zero length ----
    set_len(1, 0);
    s_rd = rd_cnt[1];
    req  = 4'b0010;
    tick();
    chk("t3z_done", done,  4'b0010);
    chk("t3z_drop", drop,  1);
    chk("t3z_rd",   rd_en, 0);
    req = '0;
    tick();
    chk("t3z_idle",  busy, 0);
    chk("t3z_reads", rd_cnt[1] - s_rd, 0);

    // ---- 4: enable dropped mid-frame ----
    set_len(3, 1518);
    set_len(0, 100);
    req = 4'b1000;
    tick();
    chk("t4_grant", grant, 4'b1000);
    repeat (100) tick();
    tx_en = 1'b0;
    req   = 4'b1001;
    s_run = run_q.size();
    wait_done("t4_wait", 2000);
    chk("t4_done", done, 4'b1000);
    req  = 4'b0001;
    nerr = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (grant !== '0 || tx_dv !== 1'b0) nerr++;
    end
    chk("t4_gated", nerr, 0);
    chk("t4_idle",  busy, 0);
    chk("t4_run",   run_q[s_run], 1526);

    // ---- 5: reset in the middle of SEND ----
    s_done0 = done_cnt[0];
    tx_en = 1'b1;
    tick();
    chk("t5_grant", grant, 4'b0001);
    repeat (38) tick();
    chk("t5_byte30", tx_d, ing_byte(0, 30));
    rst_n = 1'b0;
    req   = 4'b0101;
    set_len(2, 64);
    tick();
    chk("t5_rst_dv",    tx_dv, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy",  busy,  0);
    tick();
    rst_n = 1'b1;
    chk("t5_no_done", done_cnt[0] - s_done0, 0);
    tick();
    chk("t5_port0_first", grant, 4'b0001);
    wait_done("t5_wait0", 300);
    chk("t5_done0", done, 4'b0001);
    req = 4'b0100;
    tick();
    wait_done("t5_wait2", 300);
    chk("t5_done2", done, 4'b0100);
    req = '0;
    repeat (15) tick();

    // ---- 6: request withdrawn mid-frame ----
    set_len(1, 80);
    s_tx = tx_q.size();
    s_rd = rd_cnt[1];
    req  = 4'b0010;
    tick();
    chk("t6_grant", grant, 4'b0010);
    repeat (18) tick();
    req = '0;
    wait_done("t6_wait", 200);
    chk("t6_done", done, 4'b0010);
    repeat (14) tick();
    chk("t6_len",   tx_q.size() - s_tx, 88);
    chk("t6_reads", rd_cnt[1] - s_rd, 80);
    nerr = 0;
    for (int i = 0; i < 80; i++) if (tx_q[s_tx + 8 + i] !== ing_byte(1, i)) nerr++;
    chk("t6_bytes", nerr, 0);

    chk("protocol", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
